vend_order_ctrl: RTL

//  Customer-side order front-end for the tea/coffee vending core. Latches one coin
//  (value 1 or 2), takes a tea/coffee selection and drives the core's coin1/coin2/item

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_order_ctrl_if.sv | 45 ++++
 rtl/vend_order_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending order front-end: state codes, coin values,
// product encoding.
package vend_pkg;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE = 3'd0;
    localparam logic [STATE_W-1:0] ST_HOLD = 3'd1;
    localparam logic [STATE_W-1:0] ST_ARM  = 3'd2;
    localparam logic [STATE_W-1:0] ST_PAY1 = 3'd3;
    localparam logic [STATE_W-1:0] ST_PAY2 = 3'd4;
    localparam logic [STATE_W-1:0] ST_WAIT = 3'd5;

    localparam int unsigned COIN_W = 2;
    localparam logic [COIN_W-1:0] COIN_NONE = 2'd0;
    localparam logic [COIN_W-1:0] COIN_1    = 2'd1;
    localparam logic [COIN_W-1:0] COIN_2    = 2'd2;

    localparam logic ITEM_TEA    = 1'b1;
    localparam logic ITEM_COFFEE = 1'b0;

    function automatic logic coin_ok(input logic [COIN_W-1:0] val);
        return (val == COIN_1) || (val == COIN_2);
    endfunction

endpackage

// File: rtl/vend_order_ctrl_if.sv
// Customer and vending-core signals of the order front-end, bundled with
// modports for the controller (slave) and whatever drives it (master).
interface vend_order_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             coin_in;
    logic [1:0]       coin_val;
    logic             sel_valid;
    logic             sel_coffee;
    logic             cancel;
    logic [1:0]       tea_available;
    logic [1:0]       coffee_available;
    logic             deliver_tea;
    logic             deliver_coffee;
    logic             change;

    logic             coin1;
    logic             coin2;
    logic             item;
    logic             busy;
    logic [1:0]       credit;
    logic             coin_reject;
    logic             sold_out;
    logic             refund;
    logic             vend_done;
    logic             vend_fault;
    logic             change_err;
    logic [1:0]       refund_val;
    logic [CNT_W-1:0] vend_count;

    modport slave (
        input  coin_in, coin_val, sel_valid, sel_coffee, cancel,
               tea_available, coffee_available, deliver_tea, deliver_coffee, change,
        output coin1, coin2, item, busy, credit, coin_reject, sold_out, refund,
               vend_done, vend_fault, change_err, refund_val, vend_count
    );

    modport master (
        output coin_in, coin_val, sel_valid, sel_coffee, cancel,
               tea_available, coffee_available, deliver_tea, deliver_coffee, change,
        input  coin1, coin2, item, busy, credit, coin_reject, sold_out, refund,
               vend_done, vend_fault, change_err, refund_val, vend_count
    );

endinterface

// File: rtl/vend_order_ctrl.sv
// Order front-end: holds one coin, takes a selection, sequences coin1/coin2/item
// into the vending core and reports completion, refunds and protocol faults.
module vend_order_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned TIMEOUT = 8,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    vend_order_ctrl_if.slave   bus
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    logic [STATE_W-1:0] state_q, state_n;
    logic [COIN_W-1:0]  credit_q, credit_n;
    logic               item_q, item_n;
    logic [TMO_W-1:0]   tmo_q, tmo_n;
    logic [CNT_W-1:0]   count_q, count_n;
    logic               coin1_q, coin1_n;
    logic               coin2_q, coin2_n;
    logic               busy_q, busy_n;
    logic               coin_reject_q, coin_reject_n;
    logic               sold_out_q, sold_out_n;
    logic               refund_q, refund_n;
    logic [COIN_W-1:0]  refund_val_q, refund_val_n;
    logic               vend_done_q, vend_done_n;
    logic               vend_fault_q, vend_fault_n;
    logic               change_err_q, change_err_n;

    logic [1:0] sel_stock;
    logic       dlv_any;
    logic       dlv_match;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= COIN_NONE;
            item_q        <= ITEM_TEA;
            tmo_q         <= '0;
            count_q       <= '0;
            coin1_q       <= 1'b0;
            coin2_q       <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
            refund_q      <= 1'b0;
            refund_val_q  <= COIN_NONE;
            vend_done_q   <= 1'b0;
            vend_fault_q  <= 1'b0;
            change_err_q  <= 1'b0;
        end else begin
            state_q       <= state_n;
            credit_q      <= credit_n;
            item_q        <= item_n;
            tmo_q         <= tmo_n;
            count_q       <= count_n;
            coin1_q       <= coin1_n;
            coin2_q       <= coin2_n;
            busy_q        <= busy_n;
            coin_reject_q <= coin_reject_n;
            sold_out_q    <= sold_out_n;
            refund_q      <= refund_n;
            refund_val_q  <= refund_val_n;
            vend_done_q   <= vend_done_n;
            vend_fault_q  <= vend_fault_n;
            change_err_q  <= change_err_n;
        end
    end

    // Next state and next output values
    always_comb begin
        state_n       = state_q;
        credit_n      = credit_q;
        item_n        = item_q;
        tmo_n         = tmo_q;
        count_n       = count_q;
        coin_reject_n = 1'b0;
        sold_out_n    = 1'b0;
        refund_n      = 1'b0;
        refund_val_n  = COIN_NONE;
        vend_done_n   = 1'b0;
        vend_fault_n  = 1'b0;
        change_err_n  = 1'b0;

        sel_stock = bus.sel_coffee ? bus.coffee_available : bus.tea_available;
        dlv_any   = bus.deliver_tea | bus.deliver_coffee;
        dlv_match = (item_q == ITEM_TEA) ? (bus.deliver_tea & ~bus.deliver_coffee)
                                         : (bus.deliver_coffee & ~bus.deliver_tea);

        case (state_q)
            ST_IDLE: begin
                if (bus.coin_in) begin
                    if (coin_ok(bus.coin_val)) begin
                        credit_n = bus.coin_val;
                        state_n  = ST_HOLD;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.cancel) begin
                    refund_n     = 1'b1;
                    refund_val_n = credit_q;
                    credit_n     = COIN_NONE;
                    state_n      = ST_IDLE;
                end else if (bus.sel_valid) begin
                    if (sel_stock == 2'd0) begin
                        sold_out_n = 1'b1;
                    end else begin
                        item_n  = bus.sel_coffee ? ITEM_COFFEE : ITEM_TEA;
                        state_n = ST_ARM;
                    end
                end else if (bus.coin_in) begin
                    coin_reject_n = 1'b1;
                end
            end
            ST_ARM: begin
                tmo_n   = '0;
                state_n = ST_PAY1;
            end
            ST_PAY1: begin
                tmo_n   = tmo_q + TMO_W'(1);
                state_n = ST_PAY2;
            end
            ST_PAY2, ST_WAIT: begin
                tmo_n   = tmo_q + TMO_W'(1);
                state_n = ST_WAIT;
                if (dlv_match) begin
                    vend_done_n  = 1'b1;
                    count_n      = count_q + CNT_W'(1);
                    change_err_n = ((credit_q == COIN_2) && !bus.change) ||
                                   ((credit_q == COIN_1) &&  bus.change);
                    credit_n     = COIN_NONE;
                    state_n      = ST_IDLE;
                end else if (dlv_any || (tmo_q == TMO_W'(TIMEOUT - 1))) begin
                    vend_fault_n = 1'b1;
                    refund_n     = 1'b1;
                    refund_val_n = credit_q;
                    credit_n     = COIN_NONE;
                    state_n      = ST_IDLE;
                end
            end
            default: begin
                credit_n = COIN_NONE;
                state_n  = ST_IDLE;
            end
        endcase

        // Coins are not accepted once the order is committed to the core
        if ((state_q != ST_IDLE) && (state_q != ST_HOLD) && bus.coin_in) begin
            coin_reject_n = 1'b1;
        end

        // Coin line follows the held value for exactly the two PAY cycles
        coin1_n = ((state_n == ST_PAY1) || (state_n == ST_PAY2)) && (credit_n == COIN_1);
        coin2_n = ((state_n == ST_PAY1) || (state_n == ST_PAY2)) && (credit_n == COIN_2);
        busy_n  = (state_n != ST_IDLE);
    end

    assign bus.coin1       = coin1_q;
    assign bus.coin2       = coin2_q;
    assign bus.item        = item_q;
    assign bus.busy        = busy_q;
    assign bus.credit      = credit_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.sold_out    = sold_out_q;
    assign bus.refund      = refund_q;
    assign bus.refund_val  = refund_val_q;
    assign bus.vend_done   = vend_done_q;
    assign bus.vend_fault  = vend_fault_q;
    assign bus.change_err  = change_err_q;
    assign bus.vend_count  = count_q;

endmodule
